// File: rtl/tone_gen.sv
// Square-wave speaker driver: divides CLK_FREQ by 2*f to get a half-period,
// then toggles the speaker every half-period, retuning on half-period edges.
module tone_gen #(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] desiredFrequency,
    output logic        spkr,
    output logic        busy,
    output logic        active
);

    typedef enum logic [1:0] {
        IDLE,
        DIVIDE,
        ARM
    } state_t;

    localparam logic [31:0] DIVIDEND = CLK_FREQ[31:0];

    state_t      state_q, state_d;
    logic [31:0] cur_freq_q, cur_freq_d;
    logic [31:0] half_q, half_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] cnt_q, cnt_d;
    logic        spkr_q, spkr_d;
    logic        busy_q, busy_d;
    logic        active_q, active_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [5:0]  iter_q, iter_d;

    logic [32:0] divisor;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_nx;
    logic [31:0] quo_nx;
    logic        term;

    // The partial remainder never exceeds the dividend prefix, so 32 bits
    // hold it; only the shifted value needs the 33rd bit for the compare.
    assign divisor = {cur_freq_q, 1'b0};
    assign rem_sh  = {rem_q, quo_q[31]};
    assign fits    = rem_sh >= divisor;
    assign rem_nx  = fits ? 32'(rem_sh - divisor) : rem_sh[31:0];
    assign quo_nx  = {quo_q[30:0], fits};
    assign term    = active_q && (cnt_q == half_q - 32'd1);

    // Next-state logic: tone counter runs in every state, FSM overrides.
    always_comb begin
        state_d    = state_q;
        cur_freq_d = cur_freq_q;
        half_d     = half_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        spkr_d     = spkr_q;
        busy_d     = busy_q;
        active_d   = active_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        iter_d     = iter_q;

        if (active_q) begin
            if (term) begin
                spkr_d = ~spkr_q;
                cnt_d  = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        unique case (state_q)
            IDLE: begin
                if (desiredFrequency != cur_freq_q) begin
                    cur_freq_d = desiredFrequency;
                    if (desiredFrequency == 32'd0) begin
                        active_d = 1'b0;
                        spkr_d   = 1'b0;
                        cnt_d    = 32'd0;
                    end else begin
                        state_d = DIVIDE;
                        busy_d  = 1'b1;
                        rem_d   = 32'd0;
                        quo_d   = DIVIDEND;
                        iter_d  = 6'd0;
                    end
                end
            end
            DIVIDE: begin
                rem_d  = rem_nx;
                quo_d  = quo_nx;
                iter_d = iter_q + 6'd1;
                if (iter_q == 6'd31) begin
                    pend_d  = (quo_nx == 32'd0) ? 32'd1 : quo_nx;
                    busy_d  = 1'b0;
                    state_d = ARM;
                end
            end
            ARM: begin
                if (!active_q) begin
                    half_d   = pend_q;
                    cnt_d    = 32'd0;
                    active_d = 1'b1;
                    spkr_d   = 1'b0;
                    state_d  = IDLE;
                end else if (term) begin
                    half_d  = pend_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cur_freq_q <= 32'd0;
            half_q     <= 32'd0;
            pend_q     <= 32'd0;
            cnt_q      <= 32'd0;
            spkr_q     <= 1'b0;
            busy_q     <= 1'b0;
            active_q   <= 1'b0;
            rem_q      <= 32'd0;
            quo_q      <= 32'd0;
            iter_q     <= 6'd0;
        end else begin
            state_q    <= state_d;
            cur_freq_q <= cur_freq_d;
            half_q     <= half_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            spkr_q     <= spkr_d;
            busy_q     <= busy_d;
            active_q   <= active_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            iter_q     <= iter_d;
        end
    end

    assign spkr   = spkr_q;
    assign busy   = busy_q;
    assign active = active_q;

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: two instances (1 kHz and 50 MHz clocks) checked
// against an edge-time model of busy, active and speaker toggles.
module tb_tone_gen;

    logic        clk = 1'b0;
    logic        reset_a;
    logic        reset_b;
    logic [31:0] freq_a;
    logic [31:0] freq_b;
    logic        spkr_a, busy_a, active_a;
    logic        spkr_b, busy_b, active_b;

    int ecyc = 0;
    int errors = 0;
    int checks = 0;

    int tog_q[$];
    int brise_q[$];
    int bfall_q[$];
    int arise_q[$];

    bit          m_active[2];
    int          m_base[2];
    int          m_half[2];
    logic [31:0] m_cur[2];

    always #5 clk = ~clk;

    // Absolute rising-edge count, read on falling edges.
    always @(posedge clk) ecyc <= ecyc + 1;

    tone_gen #(.CLK_FREQ(1000)) dut_a (
        .clk              (clk),
        .reset            (reset_a),
        .desiredFrequency (freq_a),
        .spkr             (spkr_a),
        .busy             (busy_a),
        .active           (active_a)
    );

    tone_gen #(.CLK_FREQ(50_000_000)) dut_b (
        .clk              (clk),
        .reset            (reset_b),
        .desiredFrequency (freq_b),
        .spkr             (spkr_b),
        .busy             (busy_b),
        .active           (active_b)
    );

    function automatic logic o_spkr(input bit s);
        return s ? spkr_b : spkr_a;
    endfunction

    function automatic logic o_busy(input bit s);
        return s ? busy_b : busy_a;
    endfunction

    function automatic logic o_act(input bit s);
        return s ? active_b : active_a;
    endfunction

    // Expected half-period: truncated clk/(2f), at least 1.
    function automatic int mhalf(input bit s, input logic [31:0] f);
        longint unsigned fc;
        longint unsigned q;
        fc = s ? 64'd50_000_000 : 64'd1000;
        q = fc / (64'd2 * {32'd0, f});
        if (q == 0) q = 1;
        return int'(q);
    endfunction

    // First terminal edge base+h*j (j>=1) at or after edge 'from'.
    function automatic int first_tc(input int base, input int h, input int from);
        if (from <= base + h) return base + h;
        return base + h * ((from - base + h - 1) / h);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cmp_q(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
    endtask

    task automatic drive(input bit s, input logic [31:0] f);
        if (s) freq_b = f;
        else freq_a = f;
    endtask

    task automatic clear_obs();
        tog_q.delete();
        brise_q.delete();
        bfall_q.delete();
        arise_q.delete();
    endtask

    // Step falling edges until edge e, logging output transitions.
    task automatic observe(input bit s, input int e);
        logic ps, pb, pa;
        ps = o_spkr(s);
        pb = o_busy(s);
        pa = o_act(s);
        while (ecyc < e) begin
            @(negedge clk);
            if (o_spkr(s) !== ps) tog_q.push_back(ecyc);
            if (o_busy(s) && !pb) brise_q.push_back(ecyc);
            if (!o_busy(s) && pb) bfall_q.push_back(ecyc);
            if (o_act(s) && !pa) arise_q.push_back(ecyc);
            ps = o_spkr(s);
            pb = o_busy(s);
            pa = o_act(s);
        end
    endtask

    // New request from IDLE; tone model follows the retune rules.
    task automatic retune(input bit s, input logic [31:0] f, input int tail, input string tag);
        int a, h, t, e;
        int ex[$];
        int eb[$];
        int ef[$];
        int ea[$];
        a = ecyc + 1;
        drive(s, f);
        h = mhalf(s, f);
        if (m_active[s]) begin
            t = first_tc(m_base[s], m_half[s], a + 33);
            for (int x = m_base[s] + m_half[s]; x < t; x += m_half[s])
                if (x >= a) ex.push_back(x);
            ex.push_back(t);
        end else begin
            t = a + 33;
            ea.push_back(t);
        end
        e = t + 2 * h + tail;
        for (int x = t + h; x <= e; x += h) ex.push_back(x);
        eb.push_back(a);
        ef.push_back(a + 32);
        clear_obs();
        observe(s, e);
        cmp_q({tag, "_tog"}, tog_q, ex);
        cmp_q({tag, "_busy_rise"}, brise_q, eb);
        cmp_q({tag, "_busy_fall"}, bfall_q, ef);
        cmp_q({tag, "_act_rise"}, arise_q, ea);
        m_active[s] = 1'b1;
        m_base[s] = t;
        m_half[s] = h;
        m_cur[s] = f;
    endtask

    // From silence: f1, then f2 mid-divide (optionally reverted to f1).
    task automatic retune_mid(input bit s, input logic [31:0] f1, input logic [31:0] f2,
                              input int at, input bit revert, input string tag);
        int a1, h1, t1, a2, h2, t2, e;
        int ex[$];
        int eb[$];
        int ef[$];
        int ea[$];
        a1 = ecyc + 1;
        drive(s, f1);
        h1 = mhalf(s, f1);
        t1 = a1 + 33;
        ea.push_back(t1);
        eb.push_back(a1);
        ef.push_back(a1 + 32);
        if (revert) begin
            e = t1 + 3 * h1;
            for (int x = t1 + h1; x <= e; x += h1) ex.push_back(x);
            h2 = h1;
            t2 = t1;
        end else begin
            a2 = t1 + 1;
            h2 = mhalf(s, f2);
            t2 = first_tc(t1, h1, a2 + 33);
            for (int x = t1 + h1; x < t2; x += h1) ex.push_back(x);
            ex.push_back(t2);
            e = t2 + 2 * h2;
            for (int x = t2 + h2; x <= e; x += h2) ex.push_back(x);
            eb.push_back(a2);
            ef.push_back(a2 + 32);
        end
        clear_obs();
        observe(s, a1 + at - 1);
        drive(s, f2);
        if (revert) begin
            observe(s, a1 + at + 2);
            drive(s, f1);
        end
        observe(s, e);
        cmp_q({tag, "_tog"}, tog_q, ex);
        cmp_q({tag, "_busy_rise"}, brise_q, eb);
        cmp_q({tag, "_busy_fall"}, bfall_q, ef);
        cmp_q({tag, "_act_rise"}, arise_q, ea);
        m_active[s] = 1'b1;
        m_base[s] = t2;
        m_half[s] = h2;
        m_cur[s] = revert ? f1 : f2;
    endtask

    // Request 0: speaker and active drop right after the accepting edge.
    task automatic silence(input bit s, input string tag);
        drive(s, 32'd0);
        @(negedge clk);
        chk({tag, "_spkr"}, o_spkr(s), 1'b0);
        chk({tag, "_active"}, o_act(s), 1'b0);
        chk({tag, "_busy"}, o_busy(s), 1'b0);
        m_active[s] = 1'b0;
        m_cur[s] = 32'd0;
    endtask

    initial begin
        int e0;
        logic [31:0] f;
        int empty_q[$];

        m_active[0] = 1'b0;
        m_active[1] = 1'b0;
        m_cur[0] = 32'd0;
        m_cur[1] = 32'd0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        freq_a = 32'd440;
        freq_b = 32'd0;

        repeat (2) begin
            @(negedge clk);
            chk("rst_spkr", spkr_a, 1'b0);
            chk("rst_busy", busy_a, 1'b0);
            chk("rst_active", active_a, 1'b0);
        end
        reset_a = 1'b0;
        retune(0, 32'd440, 4, "a440");

        silence(0, "sil1");
        retune(0, 32'd10, 20, "a10");
        retune(0, 32'd20, 0, "a20");
        silence(0, "sil2");
        retune(0, 32'd9, 0, "a9");
        silence(0, "sil3");
        retune_mid(0, 32'd10, 32'd20, 5, 1'b0, "mid");
        silence(0, "sil4");
        retune_mid(0, 32'd10, 32'd20, 5, 1'b1, "rev");
        retune(0, 32'hFFFF_FFFF, 3, "clampA");

        reset_b = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            f = $urandom_range(25_000_000, 100_000);
            while (f == m_cur[1]) f = $urandom_range(25_000_000, 100_000);
            retune(1, f, $urandom_range(20, 0), $sformatf("rnd%0d", i));
            if ($urandom_range(3, 0) == 0) silence(1, $sformatf("rsil%0d", i));
        end
        retune(1, 32'hFFFF_FFFF, 4, "clampB");

        drive(1, 32'd1_000_000);
        repeat (10) @(negedge clk);
        chk("mid_div_busy", busy_b, 1'b1);
        reset_b = 1'b1;
        freq_b = 32'd0;
        @(negedge clk);
        chk("rstdiv_spkr", spkr_b, 1'b0);
        chk("rstdiv_busy", busy_b, 1'b0);
        chk("rstdiv_active", active_b, 1'b0);
        reset_b = 1'b0;
        clear_obs();
        e0 = ecyc + 60;
        observe(1, e0);
        cmp_q("rstdiv_tog", tog_q, empty_q);
        cmp_q("rstdiv_busy_rise", brise_q, empty_q);
        cmp_q("rstdiv_act_rise", arise_q, empty_q);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
